// File: rtl/vl_stim_pkg.sv
// Shared encodings for the four-valued stimulus sequencer: per-bit codes
// and the sweep state machine's state type.
package vl_stim_pkg;

    // Two bits per Verilog bit; the code order makes {in1,in2} a plain counter.
    localparam logic [1:0] CODE_0 = 2'b00;
    localparam logic [1:0] CODE_1 = 2'b01;
    localparam logic [1:0] CODE_X = 2'b10;
    localparam logic [1:0] CODE_Z = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DONE   = 3'd4
    } stim_state_t;

endpackage

// File: rtl/vl_stim_decode.sv
// Turns a packed 2-bit-per-bit code vector into value / X / Z bit planes so a
// simulation harness can rebuild the four-valued operand it represents.
module vl_stim_decode
    import vl_stim_pkg::*;
#(
    parameter int NBITS = 4
) (
    input  logic [2*NBITS-1:0] i_code,
    output logic [NBITS-1:0]   o_val,
    output logic [NBITS-1:0]   o_xmask,
    output logic [NBITS-1:0]   o_zmask
);

    genvar gi;
    generate
        for (gi = 0; gi < NBITS; gi++) begin : g_bit
            logic [1:0] w_digit;
            assign w_digit      = i_code[2*gi +: 2];
            assign o_val[gi]    = (w_digit == CODE_1);
            assign o_xmask[gi]  = (w_digit == CODE_X);
            assign o_zmask[gi]  = (w_digit == CODE_Z);
        end
    endgenerate

endmodule

// File: rtl/vl_stim_enum.sv
// Exhaustive four-valued stimulus sequencer: walks every {0,1,X,Z} operand pair,
// hands each to the harness over valid/ready, waits, and scores the checker bit.
module vl_stim_enum
    import vl_stim_pkg::*;
#(
    parameter int NBITS  = 4,
    parameter int SETTLE = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 vec_valid,
    input  logic                 vec_ready,
    output logic [2*NBITS-1:0]   in1_code,
    output logic [2*NBITS-1:0]   in2_code,
    input  logic                 chk_ok,
    output logic                 busy,
    output logic                 done,
    output logic [4*NBITS:0]     fail_cnt,
    output logic                 first_fail_valid,
    output logic [4*NBITS-1:0]   first_fail_vec
);

    localparam int IW = 4 * NBITS;
    localparam int CW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);

    localparam logic [IW-1:0] IDX_LAST    = '1;
    localparam logic [IW-1:0] IDX_ONE     = IW'(1);
    localparam logic [IW:0]   FAIL_ONE    = (IW + 1)'(1);
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE);
    localparam logic [CW-1:0] SETTLE_ONE  = CW'(1);

    stim_state_t     r_state;
    logic [IW-1:0]   r_index;
    logic [CW-1:0]   r_settle_cnt;
    logic            r_vec_valid;
    logic            r_busy;
    logic            r_done;
    logic [IW:0]     r_fail_cnt;
    logic            r_first_fail_valid;
    logic [IW-1:0]   r_first_fail_vec;

    // The index register is the vector itself; operands stay put in every state.
    assign in1_code         = r_index[IW-1 -: 2*NBITS];
    assign in2_code         = r_index[2*NBITS-1:0];
    assign vec_valid        = r_vec_valid;
    assign busy             = r_busy;
    assign done             = r_done;
    assign fail_cnt         = r_fail_cnt;
    assign first_fail_valid = r_first_fail_valid;
    assign first_fail_vec   = r_first_fail_vec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state            <= ST_IDLE;
            r_index            <= '0;
            r_settle_cnt       <= '0;
            r_vec_valid        <= 1'b0;
            r_busy             <= 1'b0;
            r_done             <= 1'b0;
            r_fail_cnt         <= '0;
            r_first_fail_valid <= 1'b0;
            r_first_fail_vec   <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_index            <= '0;
                        r_fail_cnt         <= '0;
                        r_first_fail_valid <= 1'b0;
                        r_first_fail_vec   <= '0;
                        r_vec_valid        <= 1'b1;
                        r_busy             <= 1'b1;
                        r_done             <= 1'b0;
                        r_state            <= ST_DRIVE;
                    end
                end

                ST_DRIVE: begin
                    if (r_vec_valid && vec_ready) begin
                        r_vec_valid <= 1'b0;
                        if (SETTLE == 0) begin
                            r_state <= ST_SAMPLE;
                        end else begin
                            r_settle_cnt <= SETTLE_LOAD;
                            r_state      <= ST_SETTLE;
                        end
                    end
                end

                ST_SETTLE: begin
                    r_settle_cnt <= r_settle_cnt - SETTLE_ONE;
                    if (r_settle_cnt <= SETTLE_ONE) begin
                        r_state <= ST_SAMPLE;
                    end
                end

                ST_SAMPLE: begin
                    if (chk_ok != 1'b1) begin
                        r_fail_cnt <= r_fail_cnt + FAIL_ONE;
                        if (!r_first_fail_valid) begin
                            r_first_fail_valid <= 1'b1;
                            r_first_fail_vec   <= r_index;
                        end
                    end
                    // Last-vector test uses the pre-increment index so it never wraps.
                    if (r_index == IDX_LAST) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_index     <= r_index + IDX_ONE;
                        r_vec_valid <= 1'b1;
                        r_state     <= ST_DRIVE;
                    end
                end

                default: begin
                    r_state     <= ST_IDLE;
                    r_vec_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vl_stim_enum.sv
// Bench for vl_stim_enum (NBITS=1, SETTLE=0 and SETTLE=3) and vl_stim_decode.
module tb_vl_stim_enum;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // DUT A: SETTLE=0, checker pass bit from a per-vector fail mask
    logic        start_a, vec_ready_a, vec_valid_a, busy_a, done_a, ffv_a;
    logic [1:0]  in1_a, in2_a;
    logic [4:0]  fail_cnt_a;
    logic [3:0]  ffvec_a;
    logic [15:0] fail_mask_a;
    logic [3:0]  code_a;
    logic        chk_ok_a;
    assign code_a   = {in1_a, in2_a};
    assign chk_ok_a = ~fail_mask_a[code_a];

    // DUT B: SETTLE=3, checker bit driven cycle by cycle
    logic        start_b, vec_ready_b, vec_valid_b, busy_b, done_b, ffv_b, chk_ok_b;
    logic [1:0]  in1_b, in2_b;
    logic [4:0]  fail_cnt_b;
    logic [3:0]  ffvec_b;

    // Decoder with NBITS=2
    logic [3:0]  dec_code;
    logic [1:0]  dec_val, dec_x, dec_z;

    vl_stim_enum #(.NBITS(1), .SETTLE(0)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a),
        .vec_valid(vec_valid_a), .vec_ready(vec_ready_a),
        .in1_code(in1_a), .in2_code(in2_a), .chk_ok(chk_ok_a),
        .busy(busy_a), .done(done_a), .fail_cnt(fail_cnt_a),
        .first_fail_valid(ffv_a), .first_fail_vec(ffvec_a)
    );

    vl_stim_enum #(.NBITS(1), .SETTLE(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b),
        .vec_valid(vec_valid_b), .vec_ready(vec_ready_b),
        .in1_code(in1_b), .in2_code(in2_b), .chk_ok(chk_ok_b),
        .busy(busy_b), .done(done_b), .fail_cnt(fail_cnt_b),
        .first_fail_valid(ffv_b), .first_fail_vec(ffvec_b)
    );

    vl_stim_decode #(.NBITS(2)) u_dec (
        .i_code(dec_code), .o_val(dec_val), .o_xmask(dec_x), .o_zmask(dec_z)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] fmask;
        int          stall_vec;
        int          stall_len;
        bit          poke;
        int          exp_acc;
        int          exp_cycles;
        int          exp_fail;
        bit          exp_ffv;
        logic [3:0]  exp_ffvec;
    } sweep_vec_t;

    typedef struct {
        logic [3:0] code;
        logic [1:0] val;
        logic [1:0] xm;
        logic [1:0] zm;
    } dec_vec_t;

    sweep_vec_t sweeps[5];
    dec_vec_t   decs[6];

    initial begin
        int cyc, acc, exp_idx, stall_left, order_err, p;

        sweeps[0] = '{16'h0000, -1, 0, 1'b0, 16, 32, 0, 1'b0, 4'h0};
        sweeps[1] = '{16'h4200, -1, 0, 1'b0, 16, 32, 2, 1'b1, 4'b1001};
        sweeps[2] = '{16'h0000,  3, 5, 1'b0, 16, 37, 0, 1'b0, 4'h0};
        sweeps[3] = '{16'h8008,  3, 5, 1'b0, 16, 37, 2, 1'b1, 4'b0011};
        sweeps[4] = '{16'h4200, -1, 0, 1'b1, 16, 32, 2, 1'b1, 4'b1001};

        decs[0] = '{4'b0000, 2'b00, 2'b00, 2'b00};
        decs[1] = '{4'b0101, 2'b11, 2'b00, 2'b00};
        decs[2] = '{4'b1000, 2'b00, 2'b10, 2'b00};
        decs[3] = '{4'b1110, 2'b00, 2'b01, 2'b10};
        decs[4] = '{4'b0110, 2'b10, 2'b01, 2'b00};
        decs[5] = '{4'b1101, 2'b01, 2'b00, 2'b10};

        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
        vec_ready_a = 1'b1; vec_ready_b = 1'b1; chk_ok_b = 1'b1;
        fail_mask_a = 16'h0000; dec_code = 4'h0;

        // Decoder table
        for (int i = 0; i < 6; i++) begin
            dec_code = decs[i].code;
            #1;
            check("dec_val", dec_val, decs[i].val);
            check("dec_x",   dec_x,   decs[i].xm);
            check("dec_z",   dec_z,   decs[i].zm);
            $display("decode code=%b val=%b x=%b z=%b", dec_code, dec_val, dec_x, dec_z);
        end

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_valid", vec_valid_a, 0);
        check("rst_busy",  busy_a, 0);
        check("rst_done",  done_a, 0);
        check("rst_codes", code_a, 0);
        check("rst_fcnt",  fail_cnt_a, 0);
        check("rst_ffv",   ffv_a, 0);
        check("rst_ffvec", ffvec_a, 0);
        check("rst_b_busy", {busy_b, vec_valid_b, done_b, ffv_b}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset mid-sweep at vector 7, after one failure has been recorded
        fail_mask_a = 16'h0004;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        cyc = 0;
        while (!(vec_valid_a && code_a == 4'd7) && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        check("midrst_reach7", code_a, 7);
        check("midrst_fcnt_before", fail_cnt_a, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", vec_valid_a, 0);
        check("midrst_busy",  busy_a, 0);
        check("midrst_codes", code_a, 0);
        check("midrst_fcnt",  fail_cnt_a, 0);
        check("midrst_ffv",   ffv_a, 0);
        check("midrst_ffvec", ffvec_a, 0);
        $display("reset mid-sweep at vector 7 done");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven sweeps on DUT A
        for (int s = 0; s < 5; s++) begin
            fail_mask_a = sweeps[s].fmask;
            start_a = 1'b1;
            @(negedge clk);
            start_a = 1'b0;
            check("start_valid", vec_valid_a, 1);
            check("start_code",  code_a, 0);
            check("start_fcnt",  fail_cnt_a, 0);
            check("start_ffv",   ffv_a, 0);
            check("start_done",  done_a, 0);
            cyc = 0; acc = 0; exp_idx = 0; order_err = 0;
            stall_left = sweeps[s].stall_len;
            while (!done_a && cyc < 400) begin
                cyc++;
                if (busy_a !== 1'b1) order_err++;
                vec_ready_a = 1'b1;
                if (vec_valid_a) begin
                    if (code_a != exp_idx[3:0]) order_err++;
                    if (exp_idx == sweeps[s].stall_vec && stall_left > 0) begin
                        vec_ready_a = 1'b0;
                        stall_left--;
                    end else begin
                        acc++;
                        exp_idx++;
                    end
                end
                start_a = (sweeps[s].poke && exp_idx == 5) ? 1'b1 : 1'b0;
                @(negedge clk);
            end
            start_a = 1'b0;
            vec_ready_a = 1'b1;
            check("sweep_done",   done_a, 1);
            check("sweep_acc",    acc, sweeps[s].exp_acc);
            check("sweep_cycles", cyc, sweeps[s].exp_cycles);
            check("sweep_order",  order_err, 0);
            check("sweep_fcnt",   fail_cnt_a, sweeps[s].exp_fail);
            check("sweep_ffv",    ffv_a, sweeps[s].exp_ffv);
            check("sweep_ffvec",  ffvec_a, sweeps[s].exp_ffvec);
            check("sweep_idle",   {busy_a, vec_valid_a}, 0);
            $display("sweep %0d: acc=%0d cycles=%0d fail_cnt=%0d ffv=%0d ffvec=%b",
                     s, acc, cyc, fail_cnt_a, ffv_a, ffvec_a);
            @(negedge clk);
            check("done_hold", done_a, 1);
        end

        // Settle interval on DUT B: only the SAMPLE-cycle chk_ok counts
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        cyc = 0; acc = 0; exp_idx = 0; order_err = 0; p = 0;
        while (!done_b && cyc < 300) begin
            cyc++;
            if ({in1_b, in2_b} != exp_idx[3:0]) order_err++;
            if (vec_valid_b) begin
                p = 0;
                acc++;
                chk_ok_b = 1'b0;
            end else begin
                p++;
                if (p == 4) chk_ok_b = !(exp_idx == 6 || exp_idx == 12);
                else        chk_ok_b = (p == 2);
            end
            @(negedge clk);
            if (p == 4) exp_idx++;
        end
        chk_ok_b = 1'b1;
        check("settle_done",   done_b, 1);
        check("settle_acc",    acc, 16);
        check("settle_cycles", cyc, 80);
        check("settle_order",  order_err, 0);
        check("settle_fcnt",   fail_cnt_b, 2);
        check("settle_ffv",    ffv_b, 1);
        check("settle_ffvec",  ffvec_b, 4'b0110);
        $display("settle sweep: acc=%0d cycles=%0d fail_cnt=%0d ffvec=%b",
                 acc, cyc, fail_cnt_b, ffvec_b);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
